regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, register data width; SHALL match the register file width.
REQ-002 Parameter REG_AW, default 2, register index width (4 registers).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 instr  input  16  instruction word: [15:12] opcode, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm8.
REQ-006 instr_valid  input  1  instr is valid this cycle.
REQ-007 instr_ready  output  1  sequencer can accept an instruction.
REQ-008 reg_dest  output  REG_AW  register file destination index.
REQ-009 reg_src1  output  REG_AW  register file source 1 index.
REQ-010 reg_src2  output  REG_AW  register file source 2 index.
REQ-011 write_data  output  DATA_W  register file write data.
REQ-012 write_enable  output  1  register file write strobe.
REQ-013 data_src1  input  DATA_W  register file read data for reg_src1 (combinational read).
REQ-014 data_src2  input  DATA_W  register file read data for reg_src2.
REQ-015 done  output  1  one-cycle pulse at instruction completion.
REQ-016 illegal_op  output  1  one-cycle pulse, coincident with done, for an undefined opcode.
REQ-017 flag_z, flag_c  output  1 each  zero and carry status flags.

Function
REQ-018 FSM states SHALL be IDLE, READ, EXEC, WB; IDLE->READ on instr_valid&&instr_ready, READ->EXEC, EXEC->WB, WB->IDLE unconditionally.
REQ-019 instr_ready SHALL be 1 only in IDLE; the accepted instr SHALL be captured into an internal instruction register (IR) on the handshake edge.
REQ-020 instr_valid while not ready SHALL be ignored; the source must hold it until accepted.
REQ-021 reg_src1/reg_src2/reg_dest SHALL be driven from IR fields continuously.
REQ-022 In READ, data_src1/data_src2 SHALL be latched into operand registers A/B.
REQ-023 In EXEC, result and next flags SHALL be computed from A, B, IR and registered.
REQ-024 Opcodes: 0 NOP; 1 ADD A+B; 2 SUB A-B; 3 AND; 4 OR; 5 XOR; 6 SHL A<<1; 7 SHR A>>1 logical; 8 LDI rd=zero-extended imm8; 9 MOV rd=A; 10-15 illegal.
REQ-025 Arithmetic SHALL be modulo 2^DATA_W; ADD flag_c = carry out; SUB flag_c = 1 iff A<B unsigned; SHL flag_c = A[15]; SHR flag_c = A[0]; AND/OR/XOR flag_c = 0.
REQ-026 Opcodes 1-7 SHALL set flag_z = (result==0); opcodes 0, 8-15 SHALL leave both flags unchanged.
REQ-027 In WB, write_enable SHALL be 1 for exactly one cycle with write_data = result, for opcodes 1-9 only; NOP and illegal SHALL produce no write.
REQ-028 done SHALL pulse during WB for every accepted instruction; illegal_op SHALL pulse during WB for opcodes 10-15.
REQ-029 Latency: handshake at edge N -> write committed at edge N+3; throughput one instruction per 4 cycles.
REQ-030 rd equal to rs1 or rs2 SHALL use pre-write operand values (read in READ precedes write in WB).
REQ-031 Back-to-back instructions SHALL observe prior writes (next READ is at least one edge after WB).
REQ-032 write_data SHALL be 0 when write_enable is 0.

Reset
REQ-033 reset SHALL force IDLE, clear IR, A, B, result, flag_z, flag_c to 0 asynchronously.
REQ-034 Under reset: instr_ready=0, write_enable=0, done=0, illegal_op=0, reg indices 0, write_data 0; instr_ready SHALL rise the first cycle after reset deasserts.
REQ-035 Reset mid-instruction SHALL abandon it with no write and no done pulse.

Structure
REQ-036 A shared package SHALL hold opcode constants, IR field bit positions, and the FSM state enum.
REQ-037 The ALU SHALL be a separate combinational sub-module seq_alu (op, A, B, imm8 -> result, z, c, z_upd, c_upd).

Verification
REQ-038 LDI R1,0x00FF; LDI R2,0x0001; ADD R3,R1,R2 -> R3=0x0100, flag_z=0, flag_c=0, write at N+3 each.
REQ-039 R1=0xFFFF, R2=0x0001, ADD R0,R1,R2 -> R0=0x0000, flag_z=1, flag_c=1; then SUB R0,R2,R1 -> R0=0x0002, flag_c=1.
REQ-040 Opcode 0xB with flags z=1,c=1 -> no write_enable, done and illegal_op pulse same cycle, flags unchanged.
REQ-041 instr_valid held high continuously with 3 instructions -> instr_ready high only in IDLE, exactly 3 done pulses, 12 cycles total.
REQ-042 Assert reset in EXEC of ADD R1 -> no write, no done, flags 0, instr_ready=1 the cycle after release.
REQ-043 SHL R2,R2 with R2=0x8001 -> R2=0x0002, flag_c=1; SHR R2,R2 -> R2=0x0001, flag_c=0.

Source files
------------

// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, instruction
// field positions and the control FSM state type.
`default_nettype none

package regfile_sequencer_pkg;

  localparam int INSTR_W = 16;
  localparam int OP_W    = 4;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 6;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 8;

  localparam logic [OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_AND = 4'd3;
  localparam logic [OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL = 4'd6;
  localparam logic [OP_W-1:0] OP_SHR = 4'd7;
  localparam logic [OP_W-1:0] OP_LDI = 4'd8;
  localparam logic [OP_W-1:0] OP_MOV = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  // Opcodes 1..9 produce a register write; 10..15 are undefined.
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return (op != OP_NOP) && (op <= OP_MOV);
  endfunction

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > OP_MOV;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_sequencer_alu.sv
// Combinational ALU for the sequencer; reports which flags the opcode updates.
`default_nettype none

module seq_alu
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IMM_W-1:0]  imm8,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c,
  output logic              z_upd,
  output logic              c_upd
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        c      = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = a << 1;
        c      = a[DATA_W-1];
      end
      OP_SHR: begin
        result = a >> 1;
        c      = a[0];
      end
      OP_LDI: result = {{(DATA_W-IMM_W){1'b0}}, imm8};
      OP_MOV: result = a;
      default: result = '0;
    endcase
  end

  // Only the arithmetic/logic group (1..7) touches the status flags.
  assign z_upd = (op >= OP_ADD) && (op <= OP_SHR);
  assign c_upd = z_upd;
  assign z     = (result == '0);

endmodule

`default_nettype wire

// File: rtl/regfile_sequencer.sv
// Four-phase (IDLE/READ/EXEC/WB) instruction sequencer driving an external
// register file with a combinational read port.
`default_nettype none

module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [REG_AW-1:0]  reg_dest,
  output logic [REG_AW-1:0]  reg_src1,
  output logic [REG_AW-1:0]  reg_src2,
  output logic [DATA_W-1:0]  write_data,
  output logic               write_enable,
  input  logic [DATA_W-1:0]  data_src1,
  input  logic [DATA_W-1:0]  data_src2,
  output logic               done,
  output logic               illegal_op,
  output logic               flag_z,
  output logic               flag_c
);

  state_t              state;
  state_t              state_next;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   result;

  logic [OP_W-1:0]     ir_op;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_z;
  logic                alu_c;
  logic                alu_z_upd;
  logic                alu_c_upd;

  assign ir_op    = ir[OP_LSB +: OP_W];
  assign reg_dest = ir[RD_LSB +: REG_AW];
  assign reg_src1 = ir[RS1_LSB +: REG_AW];
  assign reg_src2 = ir[RS2_LSB +: REG_AW];

  seq_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (ir_op),
    .a      (op_a),
    .b      (op_b),
    .imm8   (ir[IMM_LSB +: IMM_W]),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c),
    .z_upd  (alu_z_upd),
    .c_upd  (alu_c_upd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ir     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (instr_valid) ir <= instr;
        READ: begin
          op_a <= data_src1;
          op_b <= data_src2;
        end
        EXEC: begin
          result <= alu_result;
          if (alu_z_upd) flag_z <= alu_z;
          if (alu_c_upd) flag_c <= alu_c;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (instr_valid) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is masked by reset so nothing is offered while reset is held.
  always_comb begin
    instr_ready  = 1'b0;
    write_enable = 1'b0;
    write_data   = '0;
    done         = 1'b0;
    illegal_op   = 1'b0;
    case (state)
      IDLE: instr_ready = !reset;
      WB: begin
        done         = 1'b1;
        illegal_op   = op_illegal(ir_op);
        write_enable = op_writes(ir_op);
        if (op_writes(ir_op)) write_data = result;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench: directed scenarios plus random instructions checked
// against an instruction-level reference model and a behavioural register file.
`default_nettype none

module tb_regfile_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  reg_dest;
  logic [1:0]  reg_src1;
  logic [1:0]  reg_src2;
  logic [15:0] write_data;
  logic        write_enable;
  logic [15:0] data_src1;
  logic [15:0] data_src2;
  logic        done;
  logic        illegal_op;
  logic        flag_z;
  logic        flag_c;

  int checks = 0;
  int errors = 0;

  logic [15:0] rf [4];
  logic        pre_we;
  logic [1:0]  pre_idx;
  logic [15:0] pre_val;

  logic [15:0] mrf [4];
  logic        mz;
  logic        mc;

  regfile_sequencer #(
    .DATA_W (16),
    .REG_AW (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .reg_dest     (reg_dest),
    .reg_src1     (reg_src1),
    .reg_src2     (reg_src2),
    .write_data   (write_data),
    .write_enable (write_enable),
    .data_src1    (data_src1),
    .data_src2    (data_src2),
    .done         (done),
    .illegal_op   (illegal_op),
    .flag_z       (flag_z),
    .flag_c       (flag_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) rf[pre_idx] <= pre_val;
    else if (write_enable) rf[reg_dest] <= write_data;
  end

  assign data_src1 = rf[reg_src1];
  assign data_src2 = rf[reg_src2];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic preload(input logic [1:0] idx, input logic [15:0] val);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(posedge clk);
    #1 pre_we = 1'b0;
    mrf[idx] = val;
    @(negedge clk);
  endtask

  // Issues one instruction from a negedge and checks it through to IDLE.
  task automatic send_check(input logic [15:0] ins);
    logic [3:0]  op;
    logic [15:0] a, b, res;
    logic [16:0] wide;
    logic        we_exp, ill_exp, nz, nc;
    int          t;
    op = ins[15:12];
    a  = mrf[ins[9:8]];
    b  = mrf[ins[7:6]];
    nz = mz; nc = mc; we_exp = 1'b1; ill_exp = 1'b0; res = 16'h0;
    case (op)
      4'd1: begin wide = {1'b0, a} + {1'b0, b}; res = wide[15:0]; nc = wide[16]; end
      4'd2: begin res = a - b; nc = (a < b); end
      4'd3: begin res = a & b; nc = 1'b0; end
      4'd4: begin res = a | b; nc = 1'b0; end
      4'd5: begin res = a ^ b; nc = 1'b0; end
      4'd6: begin res = a * 2; nc = (a >= 16'h8000); end
      4'd7: begin res = a / 2; nc = a[0]; end
      4'd8: res = {8'h00, ins[7:0]};
      4'd9: res = a;
      4'd0: we_exp = 1'b0;
      default: begin we_exp = 1'b0; ill_exp = 1'b1; end
    endcase
    if (op >= 4'd1 && op <= 4'd7) nz = (res == 16'h0);

    instr = ins;
    instr_valid = 1'b1;
    t = 0;
    while (!instr_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!instr_ready) begin
      errors++;
      $display("FAIL accept: instr_ready=%b required 1 for instr %h", instr_ready, ins);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    // Keep valid high with junk while busy: it must be ignored.
    #1 instr = 16'($urandom);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if (write_enable !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_phase%0d: we=%b done=%b ready=%b required 0 0 0", k, write_enable, done, instr_ready);
        end
      end else begin
        instr_valid = 1'b0;
        checks++;
        if (write_enable !== we_exp) begin
          errors++;
          $display("FAIL wb_we: instr %h write_enable=%b required %b", ins, write_enable, we_exp);
        end
        checks++;
        if (done !== 1'b1 || illegal_op !== ill_exp) begin
          errors++;
          $display("FAIL wb_done: instr %h done=%b illegal=%b required 1 %b", ins, done, illegal_op, ill_exp);
        end
        checks++;
        if (we_exp && (write_data !== res || reg_dest !== ins[11:10])) begin
          errors++;
          $display("FAIL wb_data: instr %h data=%h dest=%0d required %h %0d", ins, write_data, reg_dest, res, ins[11:10]);
        end else if (!we_exp && write_data !== 16'h0) begin
          errors++;
          $display("FAIL wb_zero: instr %h write_data=%h required 0000", ins, write_data);
        end
        checks++;
        if (flag_z !== nz || flag_c !== nc) begin
          errors++;
          $display("FAIL flags: instr %h z=%b c=%b required %b %b", ins, flag_z, flag_c, nz, nc);
        end
      end
    end
    if (we_exp) mrf[ins[11:10]] = res;
    mz = nz;
    mc = nc;
    @(negedge clk);
    checks++;
    if (rf[ins[11:10]] !== mrf[ins[11:10]] || done !== 1'b0) begin
      errors++;
      $display("FAIL commit: instr %h R%0d=%h done=%b required %h 0", ins, ins[11:10], rf[ins[11:10]], done, mrf[ins[11:10]]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b0 || write_enable !== 1'b0 || done !== 1'b0 || illegal_op !== 1'b0 ||
        reg_dest !== 2'd0 || reg_src1 !== 2'd0 || reg_src2 !== 2'd0 || write_data !== 16'h0 ||
        flag_z !== 1'b0 || flag_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b we=%b done=%b ill=%b rd=%0d data=%h z=%b c=%b required all 0",
               instr_ready, write_enable, done, illegal_op, reg_dest, write_data, flag_z, flag_c);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: instr_ready=%b required 1", instr_ready);
    end
    for (int i = 0; i < 4; i++) preload(2'(i), 16'h0);
    mz = 1'b0;
    mc = 1'b0;
  endtask

  task automatic test_ldi_add();
    send_check(16'h84FF);  // LDI R1,0xFF
    send_check(16'h8801);  // LDI R2,0x01
    send_check(16'h1D80);  // ADD R3,R1,R2
    checks++;
    if (rf[3] !== 16'h0100 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
      errors++;
      $display("FAIL ldi_add: R3=%h z=%b c=%b required 0100 0 0", rf[3], flag_z, flag_c);
    end
  endtask

  task automatic test_add_sub();
    preload(2'd1, 16'hFFFF);
    preload(2'd2, 16'h0001);
    send_check(16'h1180);  // ADD R0,R1,R2
    checks++;
    if (rf[0] !== 16'h0000 || flag_z !== 1'b1 || flag_c !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: R0=%h z=%b c=%b required 0000 1 1", rf[0], flag_z, flag_c);
    end
    send_check(16'h2240);  // SUB R0,R2,R1
    checks++;
    if (rf[0] !== 16'h0002 || flag_c !== 1'b1) begin
      errors++;
      $display("FAIL sub_borrow: R0=%h c=%b required 0002 1", rf[0], flag_c);
    end
  endtask

  task automatic test_illegal();
    send_check(16'h1180);  // ADD R0,R1,R2 -> z=1,c=1
    send_check(16'hB5C3);
    checks++;
    if (flag_z !== 1'b1 || flag_c !== 1'b1 || rf[1] !== 16'hFFFF) begin
      errors++;
      $display("FAIL illegal_keep: z=%b c=%b R1=%h required 1 1 FFFF", flag_z, flag_c, rf[1]);
    end
  endtask

  task automatic test_shift();
    preload(2'd2, 16'h8001);
    send_check(16'h6A00);  // SHL R2,R2
    checks++;
    if (rf[2] !== 16'h0002 || flag_c !== 1'b1) begin
      errors++;
      $display("FAIL shl: R2=%h c=%b required 0002 1", rf[2], flag_c);
    end
    send_check(16'h7A00);  // SHR R2,R2
    checks++;
    if (rf[2] !== 16'h0001 || flag_c !== 1'b0) begin
      errors++;
      $display("FAIL shr: R2=%h c=%b required 0001 0", rf[2], flag_c);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q [3];
    int          acc, dn;
    logic        take;
    q[0] = 16'h8455; q[1] = 16'h8866; q[2] = 16'h8C77;
    acc = 0; dn = 0;
    instr = q[0];
    instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (instr_ready !== ((i % 4) == 0)) begin
        errors++;
        $display("FAIL b2b_ready: cycle %0d instr_ready=%b required %b", i, instr_ready, (i % 4) == 0);
      end
      if (done === 1'b1) dn++;
      take = instr_ready && instr_valid;
      @(posedge clk);
      #1;
      if (take) begin
        acc++;
        if (acc < 3) instr = q[acc];
        else instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (dn !== 3 || acc !== 3 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count: done=%0d accepted=%0d ready=%b required 3 3 1", dn, acc, instr_ready);
    end
    mrf[1] = 16'h0055; mrf[2] = 16'h0066; mrf[3] = 16'h0077;
    checks++;
    if (rf[1] !== mrf[1] || rf[2] !== mrf[2] || rf[3] !== mrf[3]) begin
      errors++;
      $display("FAIL b2b_regs: R1=%h R2=%h R3=%h required 0055 0066 0077", rf[1], rf[2], rf[3]);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    preload(2'd1, 16'hFFFF);
    preload(2'd2, 16'h0001);
    send_check(16'h1180);  // flags z=1,c=1 beforehand
    instr = 16'h1580;      // ADD R1,R1,R2
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);        // EXEC
    reset = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b0 || write_enable !== 1'b0 || done !== 1'b0 || flag_z !== 1'b0 ||
        flag_c !== 1'b0 || reg_dest !== 2'd0 || write_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b we=%b done=%b z=%b c=%b rd=%0d required 0 0 0 0 0 0",
               instr_ready, write_enable, done, flag_z, flag_c, reg_dest);
    end
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (write_enable !== 1'b0 || done !== 1'b0) bad++;
    end
    reset = 1'b0;
    mz = 1'b0;
    mc = 1'b0;
    @(negedge clk);
    if (write_enable !== 1'b0 || done !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_abandon: %0d cycles with write/done, required 0", bad);
    end
    checks++;
    if (instr_ready !== 1'b1 || rf[1] !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_after: ready=%b R1=%h required 1 FFFF", instr_ready, rf[1]);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) preload(2'($urandom_range(0, 3)), 16'($urandom));
      ins = {4'($urandom_range(0, 15)), 12'($urandom)};
      send_check(ins);
    end
  endtask

  initial begin
    reset       = 1'b1;
    instr       = 16'h0;
    instr_valid = 1'b0;
    pre_we      = 1'b0;
    pre_idx     = 2'd0;
    pre_val     = 16'h0;
    mz          = 1'b0;
    mc          = 1'b0;
    for (int i = 0; i < 4; i++) mrf[i] = 16'h0;
    @(negedge clk);
    test_reset();
    test_ldi_add();
    test_add_sub();
    test_illegal();
    test_shift();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
